// File: rtl/ps2_key_mapper.sv
// PS/2 keyboard receiver: frames set-2 scan bytes, then decodes E0/F0 prefixes
// into per-key held level plus one-cycle pressed/released pulses.
module ps2_key_mapper #(
  parameter int                      NUM_KEYS       = 3,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES      = {9'h172, 9'h175, 9'h029},
  parameter int                      TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kb_clk,
  input  logic                kb_data,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] released,
  output logic                scan_valid,
  output logic [7:0]          scan_code,
  output logic                frame_err
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  // clk_sync[1] is the synchronised PS/2 clock, clk_sync[2] its value one cycle earlier
  logic [2:0]          clk_sync;
  logic [1:0]          data_sync;
  logic                fall;
  logic [3:0]          bit_cnt;
  logic [8:0]          shift;
  logic [IW-1:0]       idle_cnt;
  state_t              state;
  state_t              state_next;
  logic                code_done;
  logic                code_ext;
  logic                code_brk;
  logic [NUM_KEYS-1:0] match;

  assign fall = clk_sync[2] & ~clk_sync[1];

  // Input synchronisers, idle-high after reset so no false edge is seen
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], kb_clk};
      data_sync <= {data_sync[0], kb_data};
    end
  end

  // Frame receiver: start bit, 8 data bits + parity shifted in LSB first, stop check, timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 4'd0;
      shift      <= 9'h000;
      idle_cnt   <= '0;
      scan_valid <= 1'b0;
      scan_code  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (!data_sync[1]) begin
            bit_cnt <= 4'd1;
          end
        end else if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if ((^shift) && data_sync[1]) begin
            scan_valid <= 1'b1;
            scan_code  <= shift[7:0];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift   <= {data_sync[1], shift[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt == 4'd0) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt   <= 4'd0;
        idle_cnt  <= '0;
        frame_err <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  // Decoder state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Decoder next state: prefixes accumulate, everything else returns to IDLE
  always_comb begin
    state_next = state;
    if (frame_err) begin
      state_next = IDLE;
    end else if (scan_valid) begin
      case (scan_code)
        8'hE0:   state_next = (state == BRK || state == EXT_BRK) ? IDLE : EXT;
        8'hF0:   state_next = (state == IDLE) ? BRK : (state == EXT) ? EXT_BRK : state;
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  // Decoder outputs: which table entries the completing byte hits
  always_comb begin
    code_done = 1'b0;
    match     = '0;
    code_ext  = (state == EXT) || (state == EXT_BRK);
    code_brk  = (state == BRK) || (state == EXT_BRK);
    if (scan_valid) begin
      case (scan_code)
        8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: code_done = 1'b0;
        default:                                                code_done = 1'b1;
      endcase
    end else begin
      code_done = 1'b0;
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = code_done && (KEY_CODES[9*i +: 9] == {code_ext, scan_code});
    end
  end

  // Key state; pulses fire only on an actual level change
  always_ff @(posedge clk) begin
    if (rst) begin
      held     <= '0;
      pressed  <= '0;
      released <= '0;
    end else if (code_brk) begin
      held     <= held & ~match;
      pressed  <= '0;
      released <= match & held;
    end else begin
      held     <= held | match;
      pressed  <= match & ~held;
      released <= '0;
    end
  end

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Randomised self-checking bench for ps2_key_mapper against a prefix-flag key model.
module tb_ps2_key_mapper;
  localparam int TMO  = 200;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kb_clk = 1'b1;
  logic       kb_data = 1'b1;
  logic [2:0] held, pressed, released;
  logic       scan_valid, frame_err;
  logic [7:0] scan_code;

  ps2_key_mapper #(.NUM_KEYS(3), .KEY_CODES({9'h172, 9'h175, 9'h029}), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .kb_clk(kb_clk), .kb_data(kb_data),
    .held(held), .pressed(pressed), .released(released),
    .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending-prefix flags and key table
  logic [8:0] key_tab [3] = '{9'h029, 9'h175, 9'h172};
  bit         m_ext = 1'b0, m_brk = 1'b0;
  logic [2:0] m_held = 3'b000;
  int         exp_p [3] = '{0, 0, 0};
  int         exp_r [3] = '{0, 0, 0};
  int         exp_err = 0;
  logic [7:0] exp_code_q [$];
  logic [2:0] exp_held_q [$];

  // Observations
  logic [7:0] code_q [$];
  logic [2:0] held_q [$];
  int         mon_p [3] = '{0, 0, 0};
  int         mon_r [3] = '{0, 0, 0};
  int         mon_err = 0;
  int         stray = 0;
  logic       sv_d = 1'b0, rst_d = 1'b1;
  logic [2:0] held_prev = 3'b000;

  always @(negedge clk) begin
    if (sv_d) held_q.push_back(held);
    else if (!rst && !rst_d && (held !== held_prev || (pressed | released) !== 3'b000)) stray++;
    if ((pressed & released) !== 3'b000) stray++;
    if (scan_valid) code_q.push_back(scan_code);
    if (frame_err) mon_err++;
    for (int i = 0; i < 3; i++) begin
      if (pressed[i]) mon_p[i]++;
      if (released[i]) mon_r[i]++;
    end
    sv_d = scan_valid;
    rst_d = rst;
    held_prev = held;
  end

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      if (m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
      else m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
        for (int i = 0; i < 3; i++) begin
          if (key_tab[i] == {m_ext, b}) begin
            if (m_brk) begin
              if (m_held[i]) exp_r[i]++;
              m_held[i] = 1'b0;
            end else begin
              if (!m_held[i]) exp_p[i]++;
              m_held[i] = 1'b1;
            end
          end
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    exp_code_q.push_back(b);
    exp_held_q.push_back(m_held);
  endtask

  task automatic ps2_bit(input logic v);
    kb_data = v;
    repeat (HALF) @(posedge clk);
    kb_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    kb_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    kb_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    @(negedge clk);
    if (bad_par) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      model_byte(b);
    end
  endtask

  task automatic test_reset;
    kb_clk = 1'b1;
    kb_data = 1'b1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({held, pressed, released, scan_valid, frame_err, scan_code} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got held=%b pr=%b rl=%b sv=%b fe=%b code=%h, want all zero",
               held, pressed, released, scan_valid, frame_err, scan_code);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic;
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    kb_data = 1'b1;
    send_byte(8'h29, 1'b0);
    checks++;
    if (held !== 3'b001 || mon_p[0] != 1) begin
      errors++;
      $display("FAIL basic_make: got held=%b pressed0_count=%0d, want held=001 count=1", held, mon_p[0]);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    checks++;
    if (held !== 3'b000 || mon_r[0] != 1 || mon_err != 0) begin
      errors++;
      $display("FAIL basic_break: got held=%b released0_count=%0d err=%0d, want 000 1 0", held, mon_r[0], mon_err);
    end
  endtask

  task automatic test_extended;
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    checks++;
    if (held !== 3'b010 || mon_p[1] != 1) begin
      errors++;
      $display("FAIL ext_make: got held=%b pressed1_count=%0d, want 010 1", held, mon_p[1]);
    end
    send_byte(8'h75, 1'b0);
    checks++;
    if (held !== 3'b010) begin
      errors++;
      $display("FAIL plain_vs_ext: got held=%b, want 010", held);
    end
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
    checks++;
    if (held !== 3'b000 || mon_r[1] != 1) begin
      errors++;
      $display("FAIL ext_break: got held=%b released1_count=%0d, want 000 1", held, mon_r[1]);
    end
  endtask

  task automatic test_typematic;
    for (int k = 0; k < 3; k++) send_byte(8'h29, 1'b0);
    checks++;
    if (held !== 3'b001 || mon_p[0] != 2) begin
      errors++;
      $display("FAIL typematic: got held=%b pressed0_count=%0d, want 001 2", held, mon_p[0]);
    end
    send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b0);
    checks++;
    if (held !== 3'b101) begin
      errors++;
      $display("FAIL two_keys: got held=%b, want 101", held);
    end
  endtask

  task automatic test_parity;
    int nv;
    nv = code_q.size();
    send_byte(8'h29, 1'b1);
    checks++;
    if (mon_err != 1 || code_q.size() != nv || held !== 3'b101) begin
      errors++;
      $display("FAIL bad_parity: got err=%0d new_valid=%0d held=%b, want 1 0 101", mon_err, code_q.size() - nv, held);
    end
    send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b0);
    checks++;
    if (held !== m_held || held[2] !== 1'b1) begin
      errors++;
      $display("FAIL after_parity: got held=%b, want %b", held, m_held);
    end
  endtask

  task automatic test_timeout;
    logic [2:0] h0;
    send_byte(8'hE0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    kb_data = 1'b1;
    repeat (TMO + 40) @(posedge clk);
    @(negedge clk);
    exp_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    checks++;
    if (mon_err != exp_err) begin
      errors++;
      $display("FAIL timeout_err: got err_count=%0d, want %0d", mon_err, exp_err);
    end
    h0 = held;
    send_byte(8'h72, 1'b0);
    checks++;
    if (held !== m_held || held !== h0) begin
      errors++;
      $display("FAIL timeout_idle: got held=%b, want %b", held, m_held);
    end
  endtask

  task automatic test_random;
    logic [7:0] pool [8];
    logic [7:0] b;
    pool = '{8'h29, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hAA, 8'hF0, 8'hE0};
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 7)];
      send_byte(b, $urandom_range(0, 9) == 0);
    end
    checks++;
    if (held !== m_held || mon_err != exp_err) begin
      errors++;
      $display("FAIL random_state: got held=%b err=%0d, want %b %0d", held, mon_err, m_held, exp_err);
    end
  endtask

  task automatic test_sequence;
    checks++;
    if (code_q.size() != exp_code_q.size() || held_q.size() != exp_held_q.size()) begin
      errors++;
      $display("FAIL seq_len: got %0d bytes %0d samples, want %0d", code_q.size(), held_q.size(), exp_code_q.size());
    end
    for (int k = 0; k < exp_code_q.size() && k < code_q.size() && k < held_q.size(); k++) begin
      checks++;
      if (code_q[k] !== exp_code_q[k] || held_q[k] !== exp_held_q[k]) begin
        errors++;
        $display("FAIL seq_byte%0d: got code=%h held=%b, want code=%h held=%b",
                 k, code_q[k], held_q[k], exp_code_q[k], exp_held_q[k]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mon_p[i] != exp_p[i] || mon_r[i] != exp_r[i]) begin
        errors++;
        $display("FAIL pulse_count%0d: got p=%0d r=%0d, want p=%0d r=%0d", i, mon_p[i], mon_r[i], exp_p[i], exp_r[i]);
      end
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL stray_activity: got %0d, want 0", stray);
    end
    code_q.delete(); held_q.delete(); exp_code_q.delete(); exp_held_q.delete();
  endtask

  task automatic test_reset_midframe;
    send_byte(8'h29, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b0);
    checks++;
    if (held !== 3'b111) begin
      errors++;
      $display("FAIL all_held: got held=%b, want 111", held);
    end
    test_sequence();
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    rst = 1'b1;
    kb_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({held, pressed, released, scan_valid, frame_err, scan_code} !== 19'd0) begin
      errors++;
      $display("FAIL midframe_reset: got held=%b pr=%b rl=%b sv=%b fe=%b code=%h, want all zero",
               held, pressed, released, scan_valid, frame_err, scan_code);
    end
    rst = 1'b0;
    m_held = 3'b000; m_ext = 1'b0; m_brk = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h29, 1'b0);
    checks++;
    if (held !== 3'b001 || mon_err != exp_err) begin
      errors++;
      $display("FAIL after_reset: got held=%b err=%0d, want 001 %0d", held, mon_err, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extended();
    test_typematic();
    test_parity();
    test_timeout();
    test_sequence();
    test_random();
    test_sequence();
    test_reset_midframe();
    test_sequence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_mapper.md
PS2_KEY_MAPPER -- requirements
Module: ps2_key_mapper

Interface
REQ-001 Parameter: NUM_KEYS, 3, number of tracked keys (1..32).
REQ-002 Parameter: KEY_CODES, {9'h172, 9'h175, 9'h029}, packed NUM_KEYS x 9 bit table; entry i = KEY_CODES[9i+8:9i], bit 8 = E0-extended flag, bits 7:0 = set-2 scan code (default: idx0 space, idx1 up, idx2 down).
REQ-003 Parameter: TIMEOUT_CYCLES, 50000, clk cycles with no kb_clk falling edge after which a partial frame is abandoned.
REQ-004 clk  input  1  system clock; one clock domain, all state on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 kb_clk  input  1  PS/2 clock from keyboard, asynchronous, idle high.
REQ-007 kb_data  input  1  PS/2 data from keyboard, asynchronous, idle high.
REQ-008 held  output  NUM_KEYS  level, bit i = key i currently down.
REQ-009 pressed  output  NUM_KEYS  one-cycle pulse, bit i = key i went up->down.
REQ-010 released  output  NUM_KEYS  one-cycle pulse, bit i = key i went down->up.
REQ-011 scan_valid  output  1  one-cycle pulse per correctly framed byte (prefixes included).
REQ-012 scan_code  output  8  last correctly framed byte; stable until next scan_valid.
REQ-013 frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-014 kb_clk and kb_data each pass through a 2-FF synchroniser; a falling edge = synchronised kb_clk 1 in previous cycle, 0 now; kb_data sampled (synchronised) in that cycle.
REQ-015 Frame = start(0), 8 data bits LSB first, odd parity, stop(1); bit counter 0..10.
REQ-016 Start bit sampled as 1 -> ignored, counter stays 0, no frame_err.
REQ-017 On stop-bit sample: parity odd over data+parity and stop=1 -> scan_code updated and scan_valid pulsed the next cycle; otherwise frame_err pulsed, byte discarded, decoder FSM forced to IDLE.
REQ-018 Idle counter counts cycles since last falling edge while bit counter != 0; reaching TIMEOUT_CYCLES -> counter cleared to 0, frame_err pulsed once, decoder FSM forced to IDLE.
REQ-019 Decoder FSM states IDLE, EXT, BRK, EXT_BRK, advanced only on scan_valid.
REQ-020 Byte 8'hE0: IDLE->EXT; EXT stays EXT; BRK/EXT_BRK -> IDLE (malformed, discarded).
REQ-021 Byte 8'hF0: IDLE->BRK, EXT->EXT_BRK; BRK/EXT_BRK stay unchanged.
REQ-022 Bytes 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: no key action, FSM -> IDLE.
REQ-023 Any other byte completes a code: ext = (state is EXT or EXT_BRK), brk = (state is BRK or EXT_BRK); FSM -> IDLE.
REQ-024 Completed code {ext, byte} compared against every table entry; all matching entries update (duplicates allowed); no match -> no output change.
REQ-025 Make (brk=0) on entry i: held[i]<=1; pressed[i] pulses only if held[i] was 0 (typematic repeats give no pulse).
REQ-026 Break (brk=1) on entry i: held[i]<=0; released[i] pulses only if held[i] was 1.
REQ-027 Latency: held/pressed/released update exactly 1 clk after the scan_valid pulse of the completing byte.
REQ-028 Plain code never matches an extended entry and vice versa (8'h75 without E0 does not affect up).
REQ-029 pressed and released never both high for the same bit in one cycle; all pulses exactly one cycle wide.

Reset
REQ-030 While rst=1 at posedge clk: held, pressed, released, scan_valid, frame_err = 0; scan_code = 8'h00; FSM = IDLE; bit counter and idle counter = 0; synchroniser FFs = 1.
REQ-031 rst asserted mid-frame discards the partial frame; first full frame after rst release decodes normally, no frame_err.

Verification
REQ-032 Frame 8'h29 -> scan_valid with scan_code 8'h29, next cycle held[0]=1, pressed[0] one cycle; then F0 29 -> held[0]=0, released[0] one cycle.
REQ-033 E0 75 -> held[1]=1, pressed[1]; plain 75 -> held unchanged; E0 F0 75 -> held[1]=0, released[1].
REQ-034 29, 29, 29 (typematic) -> pressed[0] pulses once, held[0]=1 throughout; E0 72 while held[0]=1 -> held=3'b101.
REQ-035 Frame 8'h29 with wrong parity -> frame_err pulse, no scan_valid, held unchanged; following good E0 72 -> held[2]=1.
REQ-036 Send E0, then 5 bits of next frame, silence TIMEOUT_CYCLES -> single frame_err, FSM IDLE; following good 72 -> no change to held (plain code).
REQ-037 rst pulsed mid-frame with held=3'b111 -> all outputs 0; next good 29 -> held[0]=1 only.
